rca_sum_accumulator: RTL and testbench

Downstream consumer of the 4-bit ripple-carry adder's 5-bit registered sum (4 sum bits plus carry-out). Accepts one sum per valid/ready handshake, accumulates `N_SAMPLES` sums into a wider accumulator, and tracks the largest sum in the batch. Presents the batch result on a registered valid/ready output port. This block is the adder's result-reduction stage, between the adder register and the system readout.

---
 rtl/adder_pkg.sv | 18 +
 rtl/acc_add_sat.sv | 31 +++
 rtl/rca_sum_accumulator.sv | 139 +++++++++++++
 tb/tb_rca_sum_accumulator.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// Shared definitions for the ripple-carry adder and its result-reduction stage.
// Holds the accumulator FSM state type and the adder result width.
package adder_pkg;

    // Adder result width: 4 sum bits plus carry-out.
    localparam int SUM_W = 5;

    // Sample counter width; wide enough for batches of up to 255 sums.
    localparam int CNT_W = 8;

    // Accumulator FSM states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } acc_state_t;

endpackage

// File: rtl/acc_add_sat.sv
// Combinational ACC_W-bit add of a zero-extended adder result.
// Reports the carry out of bit ACC_W-1 as the overflow flag.
// Build option RCA_ACC_SAT_EN: when defined, an overflowing add clamps the
// result to all ones; when undefined, the result wraps modulo 2^ACC_W.
module acc_add_sat
    import adder_pkg::*;
#(
    parameter int ACC_W = 8
) (
    input  logic [ACC_W-1:0] acc,
    input  logic [SUM_W-1:0] operand,
    output logic [ACC_W-1:0] result,
    output logic             ovf
);

    logic [ACC_W:0] wide_sum;

    // Add one bit wider than the accumulator so the carry-out is visible.
    always_comb begin
        wide_sum = {1'b0, acc} + (ACC_W + 1)'(operand);
        ovf      = wide_sum[ACC_W];
`ifdef RCA_ACC_SAT_EN
        // Clamp: once saturated, further adds of a non-negative operand
        // overflow again (or add zero), so the value stays clamped.
        result   = ovf ? '1 : wide_sum[ACC_W-1:0];
`else
        result   = wide_sum[ACC_W-1:0];
`endif
    end

endmodule

// File: rtl/rca_sum_accumulator.sv
// Result-reduction stage behind the 4-bit ripple-carry adder register.
// Accumulates N_SAMPLES 5-bit sums per batch, tracks the batch maximum and a
// sticky overflow flag, and presents the batch result on a registered
// valid/ready port. Overflow handling (wrap or clamp) is selected by the
// RCA_ACC_SAT_EN build macro inside acc_add_sat.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. in_ready depends only on state and enable (never on in_valid or
// out_ready). out_valid, once high, stays high with stable data until
// out_ready is seen high; the producer may assert in_valid at any time and
// holds in_sum until it is taken.
module rca_sum_accumulator
    import adder_pkg::*;
#(
    parameter int N_SAMPLES = 4,
    parameter int ACC_W     = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [SUM_W-1:0] in_sum,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_acc,
    output logic [SUM_W-1:0] out_max,
    output logic             out_ovf,
    output logic             busy,
    output acc_state_t       dbg_state
);

    localparam logic [CNT_W-1:0] N_LAST = CNT_W'(N_SAMPLES);

    acc_state_t       state_q, state_d;
    logic             live_q;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [SUM_W-1:0] max_q, max_d;
    logic             ovf_q, ovf_d;
    logic             out_valid_q;
    logic             busy_q;
    logic             accept;
    logic [ACC_W-1:0] add_result;
    logic             add_ovf;

    // Running sum of the accumulator and the incoming sample.
    acc_add_sat #(
        .ACC_W (ACC_W)
    ) u_add (
        .acc     (acc_q),
        .operand (in_sum),
        .result  (add_result),
        .ovf     (add_ovf)
    );

    // Input side: ready only once out of reset, when enabled, and not
    // holding a finished result.
    always_comb begin
        in_ready = live_q && enable && (state_q != DONE);
        accept   = in_valid && in_ready;
        cnt_inc  = cnt_q + CNT_W'(1);
    end

    // Next-state and datapath update for the batch FSM.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        max_d   = max_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    // First sample of a batch overwrites the previous result.
                    acc_d   = ACC_W'(in_sum);
                    max_d   = in_sum;
                    cnt_d   = CNT_W'(1);
                    ovf_d   = 1'b0;
                    state_d = (N_LAST == CNT_W'(1)) ? DONE : ACCUM;
                end
            end
            ACCUM: begin
                if (accept) begin
                    acc_d = add_result;
                    max_d = (in_sum > max_q) ? in_sum : max_q;
                    ovf_d = ovf_q | add_ovf;
                    cnt_d = cnt_inc;
                    if (cnt_inc == N_LAST) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                // Result is released regardless of enable.
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, datapath and registered status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            live_q      <= 1'b0;
            cnt_q       <= '0;
            acc_q       <= '0;
            max_q       <= '0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            live_q      <= 1'b1;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            max_q       <= max_d;
            ovf_q       <= ovf_d;
            out_valid_q <= (state_d == DONE);
            busy_q      <= (state_d != IDLE);
        end
    end

    // Output ports are driven straight from registers.
    always_comb begin
        out_valid = out_valid_q;
        out_acc   = acc_q;
        out_max   = max_q;
        out_ovf   = ovf_q;
        busy      = busy_q;
        dbg_state = state_q;
    end

endmodule

// File: tb/tb_rca_sum_accumulator.sv
// Bench for rca_sum_accumulator: three instances (N=4, N=16, N=1, ACC_W=8)
// share one stimulus stream; a behavioural batch model predicts every output.
module tb_rca_sum_accumulator;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       enable = 1'b0;
    logic       in_valid = 1'b0;
    logic [4:0] in_sum = 5'd0;
    logic       out_ready = 1'b1;

    logic       rdy    [3];
    logic       oval   [3];
    logic [7:0] acc_o  [3];
    logic [4:0] max_o  [3];
    logic       ovf_o  [3];
    logic       busy_o [3];
    adder_pkg::acc_state_t st_o [3];

    int vectors = 0;
    int miscompares = 0;

    localparam int NS [3] = '{4, 16, 1};

    // Behavioural model: phase 0 idle, 1 collecting, 2 result held.
    int m_phase [3] = '{0, 0, 0};
    int m_cnt   [3] = '{0, 0, 0};
    int m_sum   [3] = '{0, 0, 0};
    int m_mx    [3] = '{0, 0, 0};
    int m_live  [3] = '{0, 0, 0};

    always #5 clk = ~clk;

    rca_sum_accumulator #(.N_SAMPLES(4), .ACC_W(8)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .enable(enable), .in_valid(in_valid),
        .in_ready(rdy[0]), .in_sum(in_sum), .out_valid(oval[0]),
        .out_ready(out_ready), .out_acc(acc_o[0]), .out_max(max_o[0]),
        .out_ovf(ovf_o[0]), .busy(busy_o[0]), .dbg_state(st_o[0])
    );

    rca_sum_accumulator #(.N_SAMPLES(16), .ACC_W(8)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .enable(enable), .in_valid(in_valid),
        .in_ready(rdy[1]), .in_sum(in_sum), .out_valid(oval[1]),
        .out_ready(out_ready), .out_acc(acc_o[1]), .out_max(max_o[1]),
        .out_ovf(ovf_o[1]), .busy(busy_o[1]), .dbg_state(st_o[1])
    );

    rca_sum_accumulator #(.N_SAMPLES(1), .ACC_W(8)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .enable(enable), .in_valid(in_valid),
        .in_ready(rdy[2]), .in_sum(in_sum), .out_valid(oval[2]),
        .out_ready(out_ready), .out_acc(acc_o[2]), .out_max(max_o[2]),
        .out_ovf(ovf_o[2]), .busy(busy_o[2]), .dbg_state(st_o[2])
    );

    task automatic check(input string name, input int idx, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s[%0d] at %0t: got %0d, expected %0d", name, idx, $time, act, exp);
        end
    endtask

    // Batch result as seen on out_acc: true sum reduced by the overflow rule.
    function automatic int exp_acc(input int s);
`ifdef RCA_ACC_SAT_EN
        return (s > 255) ? 255 : s;
`else
        return s % 256;
`endif
    endfunction

    function automatic int exp_ready(input int i);
        return (m_live[i] != 0 && enable && m_phase[i] != 2) ? 1 : 0;
    endfunction

    // Model update on each clock edge; asynchronous reset clears everything.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) begin
                m_phase[i] = 0; m_cnt[i] = 0; m_sum[i] = 0; m_mx[i] = 0; m_live[i] = 0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (m_phase[i] == 2) begin
                    if (out_ready) m_phase[i] = 0;
                end else if (in_valid && exp_ready(i) != 0) begin
                    if (m_phase[i] == 0) begin
                        m_sum[i] = int'(in_sum);
                        m_mx[i]  = int'(in_sum);
                        m_cnt[i] = 1;
                    end else begin
                        m_sum[i] = m_sum[i] + int'(in_sum);
                        if (int'(in_sum) > m_mx[i]) m_mx[i] = int'(in_sum);
                        m_cnt[i] = m_cnt[i] + 1;
                    end
                    m_phase[i] = (m_cnt[i] == NS[i]) ? 2 : 1;
                end
                m_live[i] = 1;
            end
        end
    end

    // Every cycle: all outputs of all instances against the model.
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            check("in_ready",  i, int'(rdy[i]),    exp_ready(i));
            check("out_valid", i, int'(oval[i]),   (m_phase[i] == 2) ? 1 : 0);
            check("busy",      i, int'(busy_o[i]), (m_phase[i] != 0) ? 1 : 0);
            check("state_idle", i, int'(st_o[i] == adder_pkg::IDLE), (m_phase[i] == 0) ? 1 : 0);
            check("out_acc",   i, int'(acc_o[i]),  exp_acc(m_sum[i]));
            check("out_max",   i, int'(max_o[i]),  m_mx[i]);
            check("out_ovf",   i, int'(ovf_o[i]),  (m_sum[i] > 255) ? 1 : 0);
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Offer one sample until instance idx takes it (bounded wait).
    task automatic send(input int idx, input logic [4:0] v);
        int t;
        t = 0;
        in_valid = 1'b1;
        in_sum   = v;
        while (!rdy[idx] && t < 60) begin
            tick();
            t++;
        end
        if (t >= 60) check("send_timeout", idx, 0, 1);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        enable    = 1'b1;
        out_ready = 1'b1;
        #2 rst_n = 1'b0;
        tick();
        tick();
        // Reset values, even with enable high.
        for (int i = 0; i < 3; i++) begin
            check("rst_in_ready", i, int'(rdy[i]), 0);
            check("rst_out_valid", i, int'(oval[i]), 0);
            check("rst_acc", i, int'(acc_o[i]), 0);
            check("rst_busy", i, int'(busy_o[i]), 0);
        end
        rst_n = 1'b1;
        tick();

        // Basic batch: 3+5+31+0.
        send(0, 5'd3); send(0, 5'd5); send(0, 5'd31); send(0, 5'd0);
        check("basic_valid", 0, int'(oval[0]), 1);
        check("basic_acc", 0, int'(acc_o[0]), 39);
        check("basic_max", 0, int'(max_o[0]), 31);
        check("basic_ovf", 0, int'(ovf_o[0]), 0);
        tick();
        check("basic_pulse", 0, int'(oval[0]), 0);

        // Backpressure in DONE.
        out_ready = 1'b0;
        send(0, 5'd1); send(0, 5'd2); send(0, 5'd3); send(0, 5'd4);
        for (int k = 0; k < 5; k++) begin
            in_valid = k[0];
            in_sum   = 5'd30;
            tick();
            check("bp_valid", 0, int'(oval[0]), 1);
            check("bp_ready", 0, int'(rdy[0]), 0);
            check("bp_acc", 0, int'(acc_o[0]), 10);
            check("bp_max", 0, int'(max_o[0]), 4);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        check("bp_release_ready", 0, int'(rdy[0]), 1);
        check("bp_release_valid", 0, int'(oval[0]), 0);

        // Overflow: 16 x 31 = 496.
        do_reset();
        for (int k = 0; k < 16; k++) send(1, 5'd31);
        check("ovf_valid", 1, int'(oval[1]), 1);
`ifdef RCA_ACC_SAT_EN
        check("ovf_acc", 1, int'(acc_o[1]), 255);
`else
        check("ovf_acc", 1, int'(acc_o[1]), 240);
`endif
        check("ovf_flag", 1, int'(ovf_o[1]), 1);
        check("ovf_max", 1, int'(max_o[1]), 31);

        // Bubbles and enable low.
        do_reset();
        send(0, 5'd1); send(0, 5'd2);
        in_valid = 1'b1;
        in_sum   = 5'd20;
        enable   = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("en_low_ready", 0, int'(rdy[0]), 0);
        end
        enable   = 1'b1;
        in_valid = 1'b0;
        tick();
        send(0, 5'd4); send(0, 5'd8);
        check("en_valid", 0, int'(oval[0]), 1);
        check("en_acc", 0, int'(acc_o[0]), 15);
        check("en_max", 0, int'(max_o[0]), 8);

        // Asynchronous reset mid-batch.
        tick();
        send(0, 5'd7); send(0, 5'd9);
        #1 rst_n = 1'b0;
        #1;
        check("async_acc", 0, int'(acc_o[0]), 0);
        check("async_max", 0, int'(max_o[0]), 0);
        check("async_busy", 0, int'(busy_o[0]), 0);
        check("async_ready", 0, int'(rdy[0]), 0);
        check("async_valid", 0, int'(oval[0]), 0);
        tick();
        rst_n = 1'b1;
        tick();
        send(0, 5'd1); send(0, 5'd1); send(0, 5'd1); send(0, 5'd1);
        check("post_rst_acc", 0, int'(acc_o[0]), 4);
        check("post_rst_valid", 0, int'(oval[0]), 1);

        // Degenerate N=1.
        do_reset();
        check("n1_idle_busy", 2, int'(busy_o[2]), 0);
        send(2, 5'd17);
        check("n1_valid", 2, int'(oval[2]), 1);
        check("n1_acc", 2, int'(acc_o[2]), 17);
        check("n1_max", 2, int'(max_o[2]), 17);
        check("n1_busy", 2, int'(busy_o[2]), 1);
        tick();
        check("n1_busy_after", 2, int'(busy_o[2]), 0);
        check("n1_valid_after", 2, int'(oval[2]), 0);

        // Randomized traffic with occasional asynchronous reset pulses.
        for (int c = 0; c < 2000; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_sum    = 5'($urandom_range(0, 31));
            enable    = ($urandom_range(0, 7) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 249) == 0) begin
                #1 rst_n = 1'b0;
                #1 rst_n = 1'b1;
            end
            tick();
        end
        in_valid = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
